// File: rtl/wave_render.sv
// Oscilloscope-style waveform renderer: maps screen columns to RAM samples and lights
// the vertical segment joining neighbouring samples, two cycles behind the pixel scan.
module wave_render (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    typedef enum logic [1:0] {OUTSIDE, IN_WINDOW, DONE_ROW} row_state_t;

    row_state_t state, state_nxt;

    logic       in_window;
    logic [7:0] sample_idx;
    logic       row_entry;

    logic       s1_valid;
    logic       s1_win;
    logic [7:0] s1_level;
    logic [7:0] s1_idx;
    logic       s1_entry;

    logic [7:0] curr_sample;
    logic [7:0] prev_sample;
    logic [7:0] last_idx;

    logic [7:0] cs_new;
    logic [7:0] ps_new;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       lit;

    assign in_window  = valid && (x >= 11'd256) && (x <= 11'd767) && (y <= 10'd511);
    assign sample_idx = 8'((x - 11'd256) >> 1);

    // Address is purely combinational so a read_index swap lands on the very next fetch.
    assign read_address = in_window ? {read_index, sample_idx} : 9'd0;

    // Row FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) state <= OUTSIDE;
        else        state <= state_nxt;
    end

    // Row FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            OUTSIDE:   if (in_window) state_nxt = IN_WINDOW;
            IN_WINDOW: if ((x > 11'd767) || !valid) state_nxt = DONE_ROW;
            DONE_ROW:  state_nxt = OUTSIDE;
            default:   state_nxt = OUTSIDE;
        endcase
    end

    // Row FSM: outputs
    always_comb begin
        row_entry = 1'b0;
        if (state == OUTSIDE && in_window) row_entry = 1'b1;
    end

    // RAM data arrives during stage 1, so the segment test runs on the values about to be
    // captured; this keeps the x/y -> pixel latency at two cycles.
    always_comb begin
        cs_new = ~read_value;
        if (s1_entry)                ps_new = cs_new;
        else if (s1_idx != last_idx) ps_new = curr_sample;
        else                         ps_new = prev_sample;
        lo  = (ps_new < cs_new) ? ps_new : cs_new;
        hi  = (ps_new < cs_new) ? cs_new : ps_new;
        lit = s1_valid && s1_win && (lo <= s1_level) && (s1_level <= hi);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid          <= 1'b0;
            s1_win            <= 1'b0;
            s1_level          <= 8'd0;
            s1_idx            <= 8'd0;
            s1_entry          <= 1'b0;
            curr_sample       <= 8'd0;
            prev_sample       <= 8'd0;
            last_idx          <= 8'd0;
            valid_pixel       <= 1'b0;
            r                 <= 8'h00;
            g                 <= 8'h00;
            b                 <= 8'h00;
            wave_display_idle <= 1'b0;
        end else begin
            s1_valid <= valid;
            s1_win   <= in_window;
            s1_level <= y[8:1];
            s1_idx   <= sample_idx;
            s1_entry <= row_entry;
            if (s1_win) begin
                curr_sample <= cs_new;
                prev_sample <= ps_new;
                last_idx    <= s1_idx;
            end
            valid_pixel       <= lit;
            r                 <= 8'h00;
            g                 <= lit ? 8'hFF : 8'h00;
            b                 <= 8'h00;
            wave_display_idle <= (y > 10'd511) || !valid;
        end
    end

endmodule

// File: doc/wave_render.md
WAVE_RENDER -- requirements
Module: wave_render

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-004 x  input  11  current pixel column, 0..1279.
REQ-005 y  input  10  current pixel row, 0..1023.
REQ-006 valid  input  1  x/y denote a visible pixel this cycle.
REQ-007 read_index  input  1  sample-RAM half currently published for reading.
REQ-008 read_value  input  8  RAM data, offset-binary sample (255 = most positive), valid 1 cycle after read_address.
REQ-009 read_address  output  9  RAM read address {read_index, sample_idx[7:0]}.
REQ-010 valid_pixel  output  1  waveform pixel lit.
REQ-011 r, g, b  output  8 each  pixel color.
REQ-012 wave_display_idle  output  1  high while the block is not reading the RAM, so the writer may swap halves.

Function
REQ-013 Wave window SHALL be 256 <= x <= 767 and y <= 511; in_window = valid & window condition.
REQ-014 sample_idx SHALL equal (x - 256) >> 1, 8 bits, giving 2 columns per sample and 256 samples per sweep.
REQ-015 read_address SHALL be combinational from the current x and read_index; it SHALL be 0 outside the window.
REQ-016 Stage 1 SHALL register valid, in_window, y[8:1] (row level) and sample_idx when x/y are presented.
REQ-017 Stage 1 SHALL capture curr_sample = ~read_value (inverted, so larger samples plot higher on screen) when stage-1 in_window is 1.
REQ-018 On every curr_sample capture with a sample_idx different from the previously captured one, prev_sample SHALL take the old curr_sample value.
REQ-019 On the first in-window capture of a row (sample_idx 0 after an out-of-window cycle), prev_sample SHALL load the same value as curr_sample, so no segment is drawn from the prior row.
REQ-020 Stage 2 SHALL compute lit = in_window & (min(prev_sample, curr_sample) <= level <= max(prev_sample, curr_sample)), comparisons unsigned 8-bit, both bounds inclusive.
REQ-021 valid_pixel SHALL be registered and equal lit; total latency from x/y to valid_pixel/r/g/b SHALL be exactly 2 cycles.
REQ-022 When lit, r/g/b SHALL be 8'h00/8'hFF/8'h00; otherwise they SHALL be 8'h00/8'h00/8'h00.
REQ-023 wave_display_idle SHALL be registered and equal (y > 511) | ~valid from the previous cycle. It SHALL deassert at the cycle after the first in-window row begins.
REQ-024 read_index changing mid-row SHALL take effect on read_address in the same cycle; the pipeline SHALL NOT be flushed.
REQ-025 The block SHALL use a 3-state row FSM:
  - OUTSIDE -> IN_WINDOW when in_window = 1.
  - IN_WINDOW -> DONE_ROW when x > 767 or valid = 0.
  - DONE_ROW -> OUTSIDE on the next cycle.
  The REQ-019 reload SHALL occur on OUTSIDE -> IN_WINDOW.
REQ-026 Equal prev_sample and curr_sample SHALL light exactly one row level per column.

Reset
REQ-027 While reset = 0, all of the following SHALL be 0 on the next clk edge: pipeline registers, prev_sample, curr_sample, valid_pixel, r, g, b and wave_display_idle. The FSM SHALL go to OUTSIDE.
REQ-028 Reset asserted mid-row SHALL discard in-flight pixels. No valid_pixel SHALL assert until 2 cycles after reset returns to 1 with in_window = 1.
REQ-029 read_address SHALL remain combinational during reset.

Verification
REQ-030 Flat line: RAM holds 8'h7F at all addresses; sweep a row at y = 256 (level 128) -> valid_pixel = 1 at x = 256..767, delayed 2 cycles, g = FF; at y = 258 -> no pixels lit.
REQ-031 Step: samples 0..127 = 8'hFF, 128..255 = 8'h00; row y = 0..511 -> columns x = 512..513 are lit for all levels 0..255; other columns are lit only at one level.
REQ-032 Addressing: read_index = 1, x = 767 -> read_address = 9'h1FF; x = 256 -> 9'h100; x = 255 -> 9'h000.
REQ-033 Idle: valid = 1, y = 600 -> wave_display_idle = 1 after 1 cycle; y = 100 with in-window x -> wave_display_idle = 0 after 1 cycle.
REQ-034 Row entry: previous row ends with sample 8'h00, new row starts with 8'hFF at x = 256 -> only level 0 lit at x = 256, with no segment from the prior row.
REQ-035 Reset: drop reset to 0 during x = 400 -> next cycle valid_pixel = 0, r/g/b = 0, wave_display_idle = 0; release -> first lit pixel appears no earlier than 2 cycles later.
